fixed_requant_pipe: RTL and testbench

Two-stage pipelined fixed-point requantizer on the activation datapath, directly downstream of the activation stages (leaky ReLU and relatives). It converts each lane of a parallel block from the activation output format to the next layer's input format, using round-half-up and optional saturation. Full valid/ready backpressure is supported. A block counter marks the last block of each tensor.

---
 rtl/fixed_requant_pipe.sv | 107 ++++++++++
 tb/tb_fixed_requant_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_requant_pipe.sv
// Two-stage per-lane fixed-point requantizer with round-half-up and saturate or wrap; REQUANT_SATURATE_EN selects clamping.
// Latency: 2 cycles from input handshake to data_out_0_valid; 1 block/cycle sustained.
// Backpressure: valid/ready with bubble collapse; data_in_0_ready is combinational from data_out_0_ready.
module fixed_requant_pipe #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 2,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  output logic data_out_0_last
);

  localparam int W_IN   = DATA_IN_0_PRECISION_0;
  localparam int W_OUT  = DATA_OUT_0_PRECISION_0;
  localparam int N      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int S      = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
  localparam int LSH    = (S < 0) ? -S : 0;
  // One guard bit so the rounding add can never overflow the intermediate.
  localparam int WI     = W_IN + LSH + 1;
  localparam int BLOCKS = (DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0) *
                          (DATA_IN_0_TENSOR_SIZE_DIM_1 / DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CW     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCKS - 1);

  logic            v1;
  logic            v2;
  logic            e1;
  logic            e2;
  logic [CW-1:0]   cnt;
  logic [WI-1:0]   s1_d [N];
  logic [WI-1:0]   s1_q [N];
  logic [W_OUT-1:0] s2_d [N];
  logic [N*W_OUT-1:0] s2_q;

  assign e2 = !v2 || data_out_0_ready;
  assign e1 = !v1 || e2;

  assign data_in_0_ready  = e1;
  assign data_out_0_valid = v2;
  assign data_out_0       = s2_q;
  assign data_out_0_last  = v2 && (cnt == CNT_LAST);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [W_IN-1:0] din;
    logic signed [WI-1:0]   ext;

    assign din = data_in_0[i*W_IN +: W_IN];
    assign ext = WI'(din);

    if (S > 0) begin : g_rsh
      localparam logic signed [WI-1:0] HALF = WI'(1) << (S - 1);
      assign s1_d[i] = (ext + HALF) >>> S;
    end else if (S < 0) begin : g_lsh
      assign s1_d[i] = ext <<< LSH;
    end else begin : g_pass
      assign s1_d[i] = ext;
    end

`ifdef REQUANT_SATURATE_EN
    localparam int WX = ((WI > W_OUT) ? WI : W_OUT) + 1;
    localparam logic signed [WX-1:0] OMAX = WX'(2**(W_OUT-1) - 1);
    localparam logic signed [WX-1:0] OMIN = ~OMAX;
    logic signed [WX-1:0] x;

    assign x       = WX'(signed'(s1_q[i]));
    assign s2_d[i] = (x > OMAX) ? OMAX[W_OUT-1:0] :
                     (x < OMIN) ? OMIN[W_OUT-1:0] : x[W_OUT-1:0];
`else
    assign s2_d[i] = W_OUT'(signed'(s1_q[i]));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      cnt  <= '0;
      s2_q <= '0;
      for (int i = 0; i < N; i++) s1_q[i] <= '0;
    end else begin
      if (e1) begin
        v1 <= data_in_0_valid;
        for (int i = 0; i < N; i++) s1_q[i] <= s1_d[i];
      end
      if (e2) begin
        v2 <= v1;
        for (int i = 0; i < N; i++) s2_q[i*W_OUT +: W_OUT] <= s2_d[i];
      end
      if (data_out_0_valid && data_out_0_ready) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_requant_pipe.sv
// Bench for fixed_requant_pipe: directed table, stall/reset sequences, saturation instance, random traffic vs model.
module tb_fixed_requant_pipe;

  localparam int F_IN   = 4;
  localparam int F_OUT  = 2;
  localparam int BLOCKS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] din;
  logic        vld;
  logic        in_rdy;
  logic [15:0] dout;
  logic        ovld;
  logic        ordy;
  logic        last;

  logic [15:0] sdin;
  logic        svld;
  logic        s_in_rdy;
  logic [7:0]  sdout;
  logic        sovld;
  logic        sordy;
  logic        slast;

  fixed_requant_pipe u_dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (din),
    .data_in_0_valid  (vld),
    .data_in_0_ready  (in_rdy),
    .data_out_0       (dout),
    .data_out_0_valid (ovld),
    .data_out_0_ready (ordy),
    .data_out_0_last  (last)
  );

  fixed_requant_pipe #(
    .DATA_OUT_0_PRECISION_0 (4),
    .DATA_OUT_0_PRECISION_1 (2)
  ) u_sat (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (sdin),
    .data_in_0_valid  (svld),
    .data_in_0_ready  (s_in_rdy),
    .data_out_0       (sdout),
    .data_out_0_valid (sovld),
    .data_out_0_ready (sordy),
    .data_out_0_last  (slast)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int out_cnt  = 0;

  logic [15:0] exp_q [$];
  int          in_cyc_q [$];
  int          out_cyc_q [$];
  logic        out_last_q [$];
  logic [15:0] out_dat_q [$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_dout;
  logic        prev_last;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: scale by 2^(F_OUT-F_IN), round half toward +inf, then clamp or wrap to 8 bits.
  function automatic logic [15:0] model_blk(input logic [15:0] x);
    logic [15:0] r;
    logic [7:0]  lane;
    int          v;
    int          q;
    real         rv;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      lane = x[l*8 +: 8];
      v    = int'($signed(lane));
      rv   = $floor(real'(v) * (2.0 ** F_OUT) / (2.0 ** F_IN) + 0.5);
      q    = int'(rv);
`ifdef REQUANT_SATURATE_EN
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
`endif
      r[l*8 +: 8] = 8'(q);
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld_held", {31'd0, ovld}, 32'd1);
        check("stall_dat_held", {16'd0, dout}, {16'd0, prev_dout});
        check("stall_last_held", {31'd0, last}, {31'd0, prev_last});
      end
      if (vld && in_rdy) begin
        in_cyc_q.push_back(cyc);
        exp_q.push_back(model_blk(din));
      end
      if (ovld && ordy) begin
        out_cyc_q.push_back(cyc);
        out_last_q.push_back(last);
        out_dat_q.push_back(dout);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          check("sb_data", {16'd0, dout}, {16'd0, exp_q.pop_front()});
        end
        check("sb_last", {31'd0, last}, {31'd0, (out_cnt % BLOCKS) == BLOCKS - 1});
        out_cnt++;
      end
      prev_stall = ovld && !ordy;
      prev_dout  = dout;
      prev_last  = last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    in_cyc_q.delete();
    out_cyc_q.delete();
    out_last_q.delete();
    out_dat_q.delete();
  endtask

  task automatic drain(input int n, input string nm);
    int t;
    t = 0;
    while (out_cyc_q.size() < n && t < 200) begin
      step();
      t++;
    end
    check(nm, out_cyc_q.size(), n);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t        tbl [6];
  logic [15:0] blk [3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'hF50B, 16'hFD03};
    tbl[1] = '{16'h7FF6, 16'h20FE};
    tbl[2] = '{16'h0080, 16'h00E0};
    tbl[3] = '{16'hFA02, 16'hFF01};
    tbl[4] = '{16'h0106, 16'h0002};
    tbl[5] = '{16'h817F, 16'hE020};

    rst   = 1'b0;
    vld   = 1'b0;
    din   = '0;
    ordy  = 1'b1;
    svld  = 1'b0;
    sdin  = '0;
    sordy = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_vld", {31'd0, ovld}, 32'd0);
    check("rst_last", {31'd0, last}, 32'd0);
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("rst_sat_in_rdy", {31'd0, s_in_rdy}, 32'd1);
    rst = 1'b1;
    step();

    // Directed table, one isolated block at a time
    for (int r = 0; r < 6; r++) begin
      clear_obs();
      din = tbl[r].din;
      vld = 1'b1;
      step();
      vld = 1'b0;
      drain(1, "tbl_out_seen");
      if (out_cyc_q.size() == 1 && in_cyc_q.size() == 1) begin
        check("tbl_data", {16'd0, out_dat_q[0]}, {16'd0, tbl[r].dout});
        check("tbl_latency", out_cyc_q[0] - in_cyc_q[0], 32'd2);
        check("tbl_last", {31'd0, out_last_q[0]}, {31'd0, r[0]});
      end
    end

    // Four back-to-back blocks with ready high
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      din = 16'($urandom);
      vld = 1'b1;
      step();
    end
    vld = 1'b0;
    drain(4, "b2b_count");
    if (out_cyc_q.size() == 4) begin
      check("b2b_latency", out_cyc_q[0] - in_cyc_q[0], 32'd2);
      for (int k = 1; k < 4; k++) check("b2b_consecutive", out_cyc_q[k] - out_cyc_q[0], k);
      for (int k = 0; k < 4; k++) check("b2b_last", {31'd0, out_last_q[k]}, {31'd0, k % 2 == 1});
    end

    // Ready low for 5 cycles with 3 blocks offered
    clear_obs();
    for (int k = 0; k < 3; k++) blk[k] = 16'($urandom);
    ordy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vld = 1'b1;
      din = blk[(in_cyc_q.size() < 3) ? in_cyc_q.size() : 2];
      step();
    end
    check("stall_accepts", in_cyc_q.size(), 32'd2);
    check("stall_in_rdy_low", {31'd0, in_rdy}, 32'd0);
    check("stall_no_out", out_cyc_q.size(), 32'd0);
    din  = blk[2];
    ordy = 1'b1;
    #1;
    check("reassert_in_rdy", {31'd0, in_rdy}, 32'd1);
    step();
    vld = 1'b0;
    drain(3, "stall_out_count");
    check("stall_in_count", in_cyc_q.size(), 32'd3);

    // Narrow output instance: saturation vs wrap boundaries
    sdin = 16'h7F80;
    svld = 1'b1;
    step();
    svld = 1'b0;
    for (int t = 0; t < 10 && !sovld; t++) step();
    check("sat_vld", {31'd0, sovld}, 32'd1);
`ifdef REQUANT_SATURATE_EN
    check("sat_extremes", {24'd0, sdout}, 32'h78);
`else
    check("wrap_extremes", {24'd0, sdout}, 32'h00);
`endif
    check("sat_last_first", {31'd0, slast}, 32'd0);
    sdin = 16'hF808;
    svld = 1'b1;
    step();
    svld = 1'b0;
    for (int t = 0; t < 10 && !sovld; t++) step();
    check("sat_inrange", {24'd0, sdout}, 32'hE2);

    // Fill both stages with the counter at 1, then reset asynchronously
    ordy = 1'b1;
    vld  = 1'b1;
    din  = 16'($urandom);
    step();
    step();
    for (int t = 0; t < 10 && (out_cnt % BLOCKS) != 1; t++) begin
      din = 16'($urandom);
      step();
    end
    ordy = 1'b0;
    vld  = 1'b0;
    #1;
    check("pre_rst_vld", {31'd0, ovld}, 32'd1);
    check("pre_rst_last", {31'd0, last}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_vld", {31'd0, ovld}, 32'd0);
    check("async_rst_last", {31'd0, last}, 32'd0);
    check("async_rst_dout", {16'd0, dout}, 32'd0);
    check("async_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    exp_q.delete();
    out_cnt = 0;
    step();
    step();
    rst  = 1'b1;
    ordy = 1'b1;
    clear_obs();
    vld = 1'b1;
    din = 16'($urandom);
    step();
    din = 16'($urandom);
    step();
    vld = 1'b0;
    drain(2, "post_rst_count");
    if (out_last_q.size() == 2) begin
      check("post_rst_last0", {31'd0, out_last_q[0]}, 32'd0);
      check("post_rst_last1", {31'd0, out_last_q[1]}, 32'd1);
    end

    // Random valid/ready traffic against the reference model
    clear_obs();
    for (int k = 0; in_cyc_q.size() < 1000 && k < 20000; k++) begin
      vld  = ($urandom_range(0, 3) != 0);
      din  = 16'($urandom);
      ordy = ($urandom_range(0, 2) != 0);
      step();
    end
    vld  = 1'b0;
    ordy = 1'b1;
    check("rand_in_count", in_cyc_q.size(), 32'd1000);
    drain(1000, "rand_out_count");
    check("rand_sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
